// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator with valid/ready handshakes on both sides.
// S1 registers half-width compares; S2 merges them and selects the result by op code.
module cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c,
  output logic             err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] OP_EQ  = 3'b001;
  localparam logic [2:0] OP_NE  = 3'b010;
  localparam logic [2:0] OP_LT  = 3'b011;
  localparam logic [2:0] OP_LTU = 3'b100;
  localparam logic [2:0] OP_GE  = 3'b101;
  localparam logic [2:0] OP_GEU = 3'b110;

  // Returns {err, c} for an op code given the merged compare flags.
  function automatic logic [1:0] select_result(input logic [2:0] op, input logic eq,
                                               input logic ltu, input logic lt);
    logic [1:0] res;
    case (op)
      OP_EQ:   res = {1'b0, eq};
      OP_NE:   res = {1'b0, ~eq};
      OP_LT:   res = {1'b0, lt};
      OP_LTU:  res = {1'b0, ltu};
      OP_GE:   res = {1'b0, ~lt};
      OP_GEU:  res = {1'b0, ~ltu};
      default: res = 2'b10;
    endcase
    return res;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic             s1_hi_eq_q, s1_hi_eq_d;
  logic             s1_hi_ltu_q, s1_hi_ltu_d;
  logic             s1_lo_eq_q, s1_lo_eq_d;
  logic             s1_lo_ltu_q, s1_lo_ltu_d;
  logic             s1_a_msb_q, s1_a_msb_d;
  logic             s1_b_msb_q, s1_b_msb_d;
  logic [2:0]       s1_ctrl_q, s1_ctrl_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_c_q, s2_c_d;
  logic             s2_err_q, s2_err_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic       s2_adv_s;
  logic       accept_s;
  logic       eq_s, ltu_s, lt_s;
  logic [1:0] res_s;

  // Handshake, stage advance and next-state computation for both stages.
  always_comb begin
    s2_adv_s = ~s2_valid_q | out_ready;
    in_ready = rst_n & ~flush & (~s1_valid_q | s2_adv_s);
    accept_s = in_valid & in_ready;

    eq_s  = s1_hi_eq_q & s1_lo_eq_q;
    ltu_s = s1_hi_ltu_q | (s1_hi_eq_q & s1_lo_ltu_q);
    lt_s  = (s1_a_msb_q & ~s1_b_msb_q) | (~(s1_a_msb_q ^ s1_b_msb_q) & ltu_s);
    res_s = select_result(s1_ctrl_q, eq_s, ltu_s, lt_s);

    s1_valid_d  = s1_valid_q;
    s1_hi_eq_d  = s1_hi_eq_q;
    s1_hi_ltu_d = s1_hi_ltu_q;
    s1_lo_eq_d  = s1_lo_eq_q;
    s1_lo_ltu_d = s1_lo_ltu_q;
    s1_a_msb_d  = s1_a_msb_q;
    s1_b_msb_d  = s1_b_msb_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_c_d      = s2_c_q;
    s2_err_d    = s2_err_q;
    s2_tag_d    = s2_tag_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (~s1_valid_q | s2_adv_s) begin
        s1_valid_d = accept_s;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (s2_adv_s) begin
        s2_valid_d = s1_valid_q;
      end else begin
        s2_valid_d = s2_valid_q;
      end
    end

    if (accept_s) begin
      s1_hi_eq_d  = (a[WIDTH-1:HALF] == b[WIDTH-1:HALF]);
      s1_hi_ltu_d = (a[WIDTH-1:HALF] <  b[WIDTH-1:HALF]);
      s1_lo_eq_d  = (a[HALF-1:0] == b[HALF-1:0]);
      s1_lo_ltu_d = (a[HALF-1:0] <  b[HALF-1:0]);
      s1_a_msb_d  = a[WIDTH-1];
      s1_b_msb_d  = b[WIDTH-1];
      s1_ctrl_d   = ctrl;
      s1_tag_d    = in_tag;
    end else begin
      s1_ctrl_d   = s1_ctrl_q;
    end

    // Output data only changes when a new result moves in, so a stalled result holds.
    if (s2_adv_s & s1_valid_q & ~flush) begin
      s2_c_d   = res_s[0];
      s2_err_d = res_s[1];
      s2_tag_d = s1_tag_q;
    end else begin
      s2_tag_d = s2_tag_q;
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_hi_eq_q  <= 1'b0;
      s1_hi_ltu_q <= 1'b0;
      s1_lo_eq_q  <= 1'b0;
      s1_lo_ltu_q <= 1'b0;
      s1_a_msb_q  <= 1'b0;
      s1_b_msb_q  <= 1'b0;
      s1_ctrl_q   <= 3'b000;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_c_q      <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hi_eq_q  <= s1_hi_eq_d;
      s1_hi_ltu_q <= s1_hi_ltu_d;
      s1_lo_eq_q  <= s1_lo_eq_d;
      s1_lo_ltu_q <= s1_lo_ltu_d;
      s1_a_msb_q  <= s1_a_msb_d;
      s1_b_msb_q  <= s1_b_msb_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_c_q      <= s2_c_d;
      s2_err_q    <= s2_err_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign c         = s2_c_q;
  assign err       = s2_err_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed bench for cmp_pipe: a 32-bit instance driven from a vector table
// plus stall/flush/reset sequences, and an 8-bit instance for narrow-width checks.
module tb_cmp_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;

  logic        in_valid, in_ready, out_valid, out_ready, c, err;
  logic [31:0] a, b;
  logic [2:0]  ctrl;
  logic [4:0]  in_tag, out_tag;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, c8, err8;
  logic [7:0]  a8, b8;
  logic [2:0]  ctrl8;
  logic [4:0]  in_tag8, out_tag8;

  int checks = 0;
  int errors = 0;

  cmp_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ctrl(ctrl), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .err(err), .out_tag(out_tag)
  );

  cmp_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ctrl(ctrl8), .in_tag(in_tag8), .flush(1'b0),
    .out_valid(out_valid8), .out_ready(out_ready8), .c(c8), .err(err8), .out_tag(out_tag8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [4:0]  tag;
    logic        c;
    logic        err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  bit exp_ir  [13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  bit exp_ov  [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int exp_tag [13] = '{0, 0, 1, 1, 1, 1, 1, 2, 3, 4, 5, 6, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vc,
                      input logic [4:0] vt, input logic exp_c);
    @(negedge clk);
    in_valid8 = 1'b1; a8 = va; b8 = vb; ctrl8 = vc; in_tag8 = vt;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_valid", {31'd0, out_valid8}, 32'd1);
    check("w8_c",     {31'd0, c8}, {31'd0, exp_c});
    check("w8_err",   {31'd0, err8}, 32'd0);
    check("w8_tag",   {27'd0, out_tag8}, {27'd0, vt});
  endtask

  initial begin
    int next_tag;

    vecs[0]  = '{32'h80000000, 32'h00000001, 3'b011, 5'd1,  1'b1, 1'b0};
    vecs[1]  = '{32'h80000000, 32'h00000001, 3'b100, 5'd2,  1'b0, 1'b0};
    vecs[2]  = '{32'h1234ABCD, 32'h1234ABCD, 3'b001, 5'd3,  1'b1, 1'b0};
    vecs[3]  = '{32'h1234ABCD, 32'h1234ABCD, 3'b010, 5'd4,  1'b0, 1'b0};
    vecs[4]  = '{32'h1234ABCD, 32'h1234ABCD, 3'b110, 5'd21, 1'b1, 1'b0};
    vecs[5]  = '{32'h12340000, 32'h1233FFFF, 3'b100, 5'd6,  1'b0, 1'b0};
    vecs[6]  = '{32'h00000000, 32'h00000000, 3'b111, 5'd5,  1'b0, 1'b1};
    vecs[7]  = '{32'h00000001, 32'h00000002, 3'b000, 5'd8,  1'b0, 1'b1};
    vecs[8]  = '{32'h00000005, 32'h00000007, 3'b011, 5'd9,  1'b1, 1'b0};
    vecs[9]  = '{32'h00000005, 32'h00000007, 3'b101, 5'd10, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 32'h00000000, 3'b101, 5'd11, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000000, 3'b110, 5'd12, 1'b1, 1'b0};
    vecs[12] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 3'b011, 5'd13, 1'b1, 1'b0};
    vecs[13] = '{32'h0000FFFF, 32'h00010000, 3'b100, 5'd14, 1'b1, 1'b0};
    vecs[14] = '{32'h00010001, 32'h00010002, 3'b100, 5'd15, 1'b1, 1'b0};
    vecs[15] = '{32'h7FFFFFFF, 32'h80000000, 3'b101, 5'd16, 1'b1, 1'b0};

    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0; ctrl = 3'b000; in_tag = 5'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = 8'd0; b8 = 8'd0; ctrl8 = 3'b000; in_tag8 = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_c",         {31'd0, c}, 32'd0);
    check("rst_err",       {31'd0, err}, 32'd0);
    check("rst_tag",       {27'd0, out_tag}, 32'd0);
    check("rst_valid8",    {31'd0, out_valid8}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready",  {31'd0, in_ready}, 32'd1);

    // Back-to-back table stream, result for vector i-2 visible while i is driven
    for (int i = 0; i < NVEC + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("tbl_valid", {31'd0, out_valid}, 32'd1);
        check("tbl_c",     {31'd0, c},   {31'd0, vecs[i-2].c});
        check("tbl_err",   {31'd0, err}, {31'd0, vecs[i-2].err});
        check("tbl_tag",   {27'd0, out_tag}, {27'd0, vecs[i-2].tag});
      end
      if (i < NVEC) begin
        in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; ctrl = vecs[i].ctrl; in_tag = vecs[i].tag;
        #1;
        check("tbl_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Stall: tags 1..6 with out_ready low in cycles 3-6
    next_tag = 1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3 && cyc <= 6) ? 1'b0 : 1'b1;
      in_valid  = (next_tag <= 6);
      a = next_tag; b = 32'd3; ctrl = 3'b100; in_tag = next_tag[4:0];
      #1;
      check("stall_in_ready",  {31'd0, in_ready},  {31'd0, exp_ir[cyc-1]});
      check("stall_out_valid", {31'd0, out_valid}, {31'd0, exp_ov[cyc-1]});
      if (exp_ov[cyc-1]) begin
        check("stall_tag", {27'd0, out_tag}, exp_tag[cyc-1]);
        check("stall_c",   {31'd0, c}, (exp_tag[cyc-1] < 3) ? 32'd1 : 32'd0);
      end
      if (in_valid && exp_ir[cyc-1]) next_tag++;
    end
    in_valid = 1'b0;

    // Flush with both stages full and a request presented
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd9; b = 32'd9; ctrl = 3'b001; in_tag = 5'd20;
    @(negedge clk);
    in_tag = 5'd21;
    @(negedge clk);
    check("fl_full_valid", {31'd0, out_valid}, 32'd1);
    check("fl_full_tag",   {27'd0, out_tag}, 32'd20);
    flush = 1'b1; in_tag = 5'd22;
    #1;
    check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_cleared", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fl_quiet", {31'd0, out_valid}, 32'd0);
    end

    // Narrow instance
    run8(8'hFF, 8'h01, 3'b011, 5'd3, 1'b1);
    run8(8'hFF, 8'h01, 3'b100, 5'd4, 1'b0);
    run8(8'h7F, 8'h80, 3'b101, 5'd7, 1'b1);
    run8(8'h10, 8'h0F, 3'b100, 5'd9, 1'b0);

    // Reset mid-stream discards in-flight requests on both instances
    @(negedge clk);
    in_valid = 1'b1; a = 32'd1; b = 32'd2; ctrl = 3'b011; in_tag = 5'd7;
    in_valid8 = 1'b1; a8 = 8'd1; b8 = 8'd2; ctrl8 = 3'b011; in_tag8 = 5'd7;
    @(negedge clk);
    in_tag = 5'd8; in_tag8 = 5'd8;
    @(negedge clk);
    check("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; in_valid8 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mr_valid",    {31'd0, out_valid}, 32'd0);
    check("mr_valid8",   {31'd0, out_valid8}, 32'd0);
    check("mr_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_quiet",  {31'd0, out_valid}, 32'd0);
      check("mr_quiet8", {31'd0, out_valid8}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
